// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed 7-segment driver for the stopwatch (MM.SS).
// Freezes the digit counts once per frame so a carry in progress never shows
// half-updated, blanks leading zeros on request and blinks the digit selected
// for adjustment. All display outputs are registered and active-low.
module seg_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       adj_en,
  input  logic [1:0] adj_sel,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_OFF   = 7'h7F;

  // Scan slot: which digit is currently being driven.
  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_t;

  slot_t         r_slot;
  slot_t         w_slot_nxt;
  logic [PW-1:0] r_presc;
  logic [FW-1:0] r_frame;
  logic          r_phase;
  logic [3:0]    r_snap0;
  logic [3:0]    r_snap1;
  logic [3:0]    r_snap2;
  logic [3:0]    r_snap3;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_dp;

  logic          w_tick;
  logic          w_capture;
  logic [3:0]    w_cur;
  logic          w_lead3;
  logic          w_lead2;
  logic          w_lead1;
  logic          w_lead_blank;
  logic          w_blink_blank;
  logic          w_blank;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_an_nxt;
  logic          w_dp_nxt;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show nothing.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_OFF;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  assign w_tick    = (r_presc == PRESC_MAX);
  assign w_capture = w_tick && (r_slot == SLOT3);

  // Prescaler: counts clocks within one digit slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Slot register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot <= SLOT0;
    end else begin
      r_slot <= w_slot_nxt;
    end
  end

  // Slot sequencing: advance one digit per prescaler wrap.
  always_comb begin
    w_slot_nxt = r_slot;
    if (w_tick) begin
      case (r_slot)
        SLOT0:   w_slot_nxt = SLOT1;
        SLOT1:   w_slot_nxt = SLOT2;
        SLOT2:   w_slot_nxt = SLOT3;
        SLOT3:   w_slot_nxt = SLOT0;
        default: w_slot_nxt = SLOT0;
      endcase
    end
  end

  // Snapshot: freeze all four counts on the edge that ends a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap0 <= '0;
      r_snap1 <= '0;
      r_snap2 <= '0;
      r_snap3 <= '0;
    end else if (w_capture) begin
      r_snap0 <= digit0;
      r_snap1 <= digit1;
      r_snap2 <= digit2;
      r_snap3 <= digit3;
    end
  end

  // Blink timebase: count frames, toggle the phase every BLINK_DIV frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame <= '0;
      r_phase <= 1'b0;
    end else if (w_capture) begin
      if (r_frame == FRAME_MAX) begin
        r_frame <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frame <= r_frame + FW'(1);
      end
    end
  end

  // Leading-zero chain: a digit may only be suppressed if every more
  // significant digit is suppressed too.
  assign w_lead3 = blank_lead && (r_snap3 == 4'd0);
  assign w_lead2 = w_lead3    && (r_snap2 == 4'd0);
  assign w_lead1 = w_lead2    && (r_snap1 == 4'd0);

  // Next display word for the slot currently selected.
  always_comb begin
    w_cur        = r_snap0;
    w_lead_blank = 1'b0;
    case (r_slot)
      SLOT0: begin
        w_cur        = r_snap0;
        w_lead_blank = 1'b0;
      end
      SLOT1: begin
        w_cur        = r_snap1;
        w_lead_blank = w_lead1;
      end
      SLOT2: begin
        w_cur        = r_snap2;
        w_lead_blank = w_lead2;
      end
      SLOT3: begin
        w_cur        = r_snap3;
        w_lead_blank = w_lead3;
      end
      default: begin
        w_cur        = r_snap0;
        w_lead_blank = 1'b0;
      end
    endcase
    w_blink_blank = adj_en && (adj_sel == r_slot) && r_phase;
    w_blank       = w_lead_blank || w_blink_blank;
    w_seg_nxt     = w_blank ? SEG_OFF : bcd_to_seg(w_cur);
    w_an_nxt      = ~(4'b0001 << r_slot);
    w_dp_nxt      = !((r_slot == SLOT2) && !w_blank);
  end

  // Output register: display lags the slot by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg <= SEG_OFF;
      r_an  <= '1;
      r_dp  <= 1'b1;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed frames with hand-decoded expected displays pushed to a
// queue; an independent monitor pops one entry every time a new anode appears.
module tb_seg_scan;

  logic       clk;
  logic       rst;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       adj_en;
  logic [1:0] adj_sel;
  logic       blank_lead;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  typedef struct packed {
    logic [15:0] tag;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } exp_t;

  exp_t q[$];
  int   errors;
  int   checks;
  logic mon_en;
  int   fr;

  seg_scan #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .adj_en     (adj_en),
    .adj_sel    (adj_sel),
    .blank_lead (blank_lead),
    .seg        (seg),
    .an         (an),
    .dp         (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic push(input int slot, input logic [6:0] s, input logic d);
    exp_t e;
    e.tag = 16'((fr << 2) | slot);
    e.an  = ~(4'b0001 << slot);
    e.seg = s;
    e.dp  = d;
    q.push_back(e);
  endtask

  // One display frame (16 clks). Control inputs apply to this frame; the new
  // digit counts are presented after 'dly' edges and are captured at frame end.
  task automatic frame(input logic bl, input logic ae, input logic [1:0] as,
                       input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input logic edp,
                       input logic [3:0] n0, input logic [3:0] n1,
                       input logic [3:0] n2, input logic [3:0] n3, input int dly);
    blank_lead = bl;
    adj_en     = ae;
    adj_sel    = as;
    push(0, s0, 1'b1);
    push(1, s1, 1'b1);
    push(2, s2, edp);
    push(3, s3, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k == dly) begin
        digit0 = n0;
        digit1 = n1;
        digit2 = n2;
        digit3 = n3;
      end
      @(posedge clk);
    end
    #1;
    fr++;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mon_en = 1'b0;
    fr     = 0;
    rst        = 1'b1;
    digit0     = 4'd0;
    digit1     = 4'd0;
    digit2     = 4'd0;
    digit3     = 4'd0;
    adj_en     = 1'b0;
    adj_sel    = 2'd0;
    blank_lead = 1'b0;
    fork
      // Monitor: one comparison per newly driven anode, plus slot length.
      begin
        logic [3:0] prev_an;
        int         hold;
        exp_t       e;
        prev_an = 4'hF;
        hold    = 0;
        forever begin
          @(negedge clk);
          if (mon_en) begin
            if (an !== prev_an) begin
              if (an !== 4'hF && prev_an !== 4'hF)
                check("slot_len", 32'(hold), 32'd4);
              if (an !== 4'hF) begin
                if (q.size() == 0) begin
                  check("queue_underflow", {20'd0, an, seg, dp}, 32'hFFFFFFFF);
                end else begin
                  e = q.pop_front();
                  check($sformatf("frame%0d_slot%0d", e.tag >> 2, e.tag & 16'd3),
                        {20'd0, an, seg, dp}, {20'd0, e.an, e.seg, e.dp});
                end
              end
              hold = 1;
            end else begin
              hold++;
            end
            prev_an = an;
          end
        end
      end
      // Stimulus.
      begin
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_an", 32'(an), 32'hF);
        check("reset_dp", 32'(dp), 32'h1);
        mon_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        // Power-up frame shows 0000, then 1234.
        frame(0, 0, 2'd0, 7'h40, 7'h40, 7'h40, 7'h40, 0, 4'd1, 4'd2, 4'd3, 4'd4, 0);
        frame(0, 0, 2'd0, 7'h79, 7'h24, 7'h30, 7'h19, 0, 4'd9, 4'd5, 4'd9, 4'd0, 0);
        // Tearing: inputs change during slot 1, old frame must stay intact.
        frame(0, 0, 2'd0, 7'h10, 7'h12, 7'h10, 7'h40, 0, 4'd0, 4'd0, 4'd0, 4'd1, 6);
        frame(0, 0, 2'd0, 7'h40, 7'h40, 7'h40, 7'h79, 0, 4'd5, 4'd0, 4'd0, 4'd0, 0);
        // Leading-zero suppression.
        frame(1, 0, 2'd0, 7'h12, 7'h7F, 7'h7F, 7'h7F, 1, 4'd0, 4'd0, 4'd0, 4'd0, 0);
        frame(1, 0, 2'd0, 7'h40, 7'h7F, 7'h7F, 7'h7F, 1, 4'd3, 4'd0, 4'd4, 4'd0, 0);
        frame(1, 0, 2'd0, 7'h30, 7'h40, 7'h19, 7'h7F, 0, 4'd7, 4'd3, 4'd8, 4'd1, 0);
        // Blink digit 2: phase is 1 in frames 7,10,11, 0 in frames 8,9,12.
        frame(0, 1, 2'd2, 7'h78, 7'h30, 7'h7F, 7'h79, 1, 4'd7, 4'd3, 4'd8, 4'd1, 0);
        frame(0, 1, 2'd2, 7'h78, 7'h30, 7'h00, 7'h79, 0, 4'd7, 4'd3, 4'd8, 4'd1, 0);
        frame(0, 1, 2'd2, 7'h78, 7'h30, 7'h00, 7'h79, 0, 4'd7, 4'd3, 4'd8, 4'd1, 0);
        frame(0, 1, 2'd2, 7'h78, 7'h30, 7'h7F, 7'h79, 1, 4'd7, 4'd3, 4'd8, 4'd1, 0);
        frame(0, 1, 2'd2, 7'h78, 7'h30, 7'h7F, 7'h79, 1, 4'd7, 4'd3, 4'd8, 4'd1, 0);
        frame(0, 1, 2'd2, 7'h78, 7'h30, 7'h00, 7'h79, 0, 4'd7, 4'hC, 4'd8, 4'd1, 0);
        // Invalid BCD on digit 1, then blink on digit 0 (phase 1 in frame 14).
        frame(0, 0, 2'd0, 7'h78, 7'h7F, 7'h00, 7'h79, 0, 4'd7, 4'hC, 4'd8, 4'd1, 0);
        frame(0, 1, 2'd0, 7'h7F, 7'h7F, 7'h00, 7'h79, 0, 4'd7, 4'hC, 4'd8, 4'd1, 0);
        // Mid-frame reset at slot 3, prescaler 2.
        adj_en = 1'b0;
        push(0, 7'h78, 1'b1);
        push(1, 7'h7F, 1'b1);
        push(2, 7'h00, 1'b0);
        push(3, 7'h79, 1'b1);
        repeat (14) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_seg", 32'(seg), 32'h7F);
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_dp", 32'(dp), 32'h1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fr = 100;
        // Restart: snapshot back to 0000, blink phase cleared.
        frame(0, 1, 2'd0, 7'h40, 7'h40, 7'h40, 7'h40, 0, 4'd2, 4'd6, 4'd0, 4'd9, 0);
        frame(0, 1, 2'd0, 7'h24, 7'h02, 7'h40, 7'h10, 0, 4'd2, 4'd6, 4'd0, 4'd9, 0);
        frame(0, 1, 2'd0, 7'h7F, 7'h02, 7'h40, 7'h10, 0, 4'd2, 4'd6, 4'd0, 4'd9, 0);
        mon_en = 1'b0;
        check("queue_drained", 32'(q.size()), 32'd0);
      end
      // Watchdog.
      begin
        #100000;
        check("watchdog", 32'd1, 32'd0);
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Reads the four BCD counts produced by the stopwatch's cascaded digit counters and drives a 4-digit, common-anode, multiplexed 7-segment display.
- Display format is MM.SS; digit 0 = seconds ones, digit 3 = minutes tens.
- Provides:
  - coherent per-frame snapshots (no tearing while counters carry),
  - leading-zero blanking,
  - blinking of the digit selected for adjustment.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is driven; legal range is 2 and up.
- BLINK_DIV, 64, full scan frames per blink half-period; legal range is 1 and up.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- digit0  in  4  BCD seconds ones
- digit1  in  4  BCD seconds tens
- digit2  in  4  BCD minutes ones
- digit3  in  4  BCD minutes tens
- adj_en  in  1  adjust mode; enables blinking of the selected digit
- adj_sel  in  2  index of the digit being adjusted
- blank_lead  in  1  1 = suppress leading zeros
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  4  digit anodes, one-hot, active-low; an[i] drives digit i
- dp  out  1  decimal point, active-low

Behaviour:

Reset (rst=0, asynchronous, all outputs registered):
- seg=7'h7F, an=4'hF, dp=1.
- Prescaler=0, index=0, snapshot digits=0, frame counter=0, blink phase=0.

Prescaler and scan index:
- Prescaler counts 0..SCAN_DIV-1 and wraps.
- tick = (prescaler==SCAN_DIV-1).
- On tick, index advances 0→1→2→3→0 (2-bit wrap).

Snapshot:
- On tick with index==3, all four digit inputs are captured into snap0..snap3 in the same edge. The new frame starting at index 0 therefore displays values from one instant.
- Inputs changing at any other time have no effect until the next capture.
- Until the first capture after reset, snapshot reads 0000.

Blink:
- The frame counter increments on each capture and counts 0..BLINK_DIV-1.
- On wrap the blink phase toggles. Half-period = BLINK_DIV*4*SCAN_DIV clks.

Blanking for digit i, evaluated on snapshot values:
- Digit 3 lead-blank: blank_lead && snap3==0.
- Digit 2 lead-blank: digit 3 lead-blank && snap2==0.
- Digit 1 lead-blank: digit 2 lead-blank && snap1==0.
- Digit 0 is never lead-blanked.
- Blink-blank: adj_en && adj_sel==i && phase==1.
- A digit is blanked if it is lead-blanked or blink-blanked. Blanked means seg=7'h7F; the anode is still driven.

Decode, active-low {g..a}:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Codes 10–15 decode to 7'h7F (blank).

Decimal point:
- dp=0 only while index==2 and digit 2 is not blanked; otherwise dp=1.

Latency:
- seg/an/dp are registered from the current index and snapshot.
- Outputs reflect an index change exactly 1 clk after the tick edge.
- First clk after reset release: an=4'b1110, seg shows snap0 ('0' → 7'h40).

Other rules:
- Exactly one an bit is low at all times after the first post-reset edge.
- adj_en, adj_sel and blank_lead are sampled combinationally into the output register each cycle; they are not snapshotted.
- Reset asserted mid-frame returns everything to reset values immediately. The frame restarts at index 0 with the snapshot at 0000.

Test Plan (SCAN_DIV=4, BLINK_DIV=2):
1. Reset, then release with inputs 1,2,3,4 and blank_lead=0.
   - Frame 1 shows 0000: seg=40 on each anode.
   - From the second frame: an=1110/seg=79, an=1101/seg=24, an=1011/seg=30 with dp=0, an=0111/seg=19.
   - Each digit is held 4 clks.
2. Tearing check: change digit inputs from 9,5,9,0 to 0,0,0,1 while index=1.
   - The remainder of the current frame still shows the old values.
   - The new values appear only from the next index-0 slot.
3. Leading zeros: blank_lead=1, digits 5,0,0,0.
   - an3, an2 and an1 slots show seg=7F; dp=1 in the an2 slot.
   - Digit 0 shows 12.
   - With digits 0,0,0,0, digit 0 shows 40.
4. Blink: adj_en=1, adj_sel=2, digits 7,3,8,1.
   - The digit 2 slot alternates between 00 and 7F every 2 frames (32 clks).
   - dp is suppressed while digit 2 is blanked.
   - The other digits are unaffected.
5. Invalid BCD: digit1=4'hC → the digit 1 slot shows 7F, and no other digit changes.
6. Mid-frame reset: pulse rst=0 at index=3, prescaler=2.
   - seg=7F and an=F are driven immediately, before any clk edge.
   - After release, scanning resumes at index 0 and the frame counter and blink phase are cleared.
